bash_line_arbiter: RTL and testbench

- Shares the single bash output channel (display-memory line interface: ready/char/next plus solved handshake) between NUM_REQ line-producing command modules, e.g. echo and future command handlers.
- Grants whole lines round-robin, never interrupts a line in progress, and holds off new grants while the bash input side is delivering a typed line.
- Sits between the command modules and the video-memory/bash I/O block.

---
 rtl/bash_line_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bash_line_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_line_arbiter.sv
// bash_line_arbiter
//   Shares the single bash output channel (ready/char/next line interface
//   plus solved/ack handshake) between NUM_REQ line-producing command
//   modules. Whole lines are granted round-robin. A line in progress is never
//   interrupted. No new grant is issued while the bash input side is reading
//   out a typed line.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   req_ready     per requester: has a line to print
//   req_char      per requester current character, slice i = [8i+7:8i]
//   req_next      per requester: advance one character (owner only)
//   req_solved    per requester: line finished pulse
//   req_done      per requester: display acknowledged the line (pulse)
//   con_busy      bash input line is being read out; blocks new grants
//   con_next      display requests next character
//   con_ready     to display: line in progress
//   con_char      to display: current character
//   con_solved    to display: line finished pulse
//   con_ack       display finished processing con_solved
//   grant_valid   a requester owns the channel
//   grant_id      index of the owner (holds its last value while idle)
//   err_timeout   sticky: a line was released because con_ack never came
module bash_line_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_char,
  output logic [NUM_REQ-1:0]   req_next,
  input  logic [NUM_REQ-1:0]   req_solved,
  output logic [NUM_REQ-1:0]   req_done,
  input  logic                 con_busy,
  input  logic                 con_next,
  output logic                 con_ready,
  output logic [7:0]           con_char,
  output logic                 con_solved,
  input  logic                 con_ack,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  // The counter reads 0 in the first WAIT_ACK cycle, so this value marks the
  // ACK_TIMEOUT-th cycle spent waiting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 grant_valid_q, grant_valid_d;
  logic                 con_solved_q, con_solved_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W:0]        pick_s;

  // Round-robin search: first set bit of ready at or after start, wrapping.
  // Returns {found, index}. Walking offsets from high to low and overwriting
  // leaves the smallest offset as the winner.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] ready,
                                            input logic [ID_W-1:0]    start);
    logic [ID_W:0] res;
    int            idx;
    res = {(ID_W+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (ready[ID_W'(idx)]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate for the next grant.
  always_comb begin
    pick_s = rr_pick(req_ready, rr_ptr_q);
  end

  // Next-state logic and the combinational channel pass-through.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    con_solved_d  = 1'b0;
    req_done_d    = {NUM_REQ{1'b0}};
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    con_ready     = 1'b0;
    con_char      = 8'h00;
    req_next      = {NUM_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (!con_busy && pick_s[ID_W]) begin
          grant_id_d    = pick_s[ID_W-1:0];
          grant_valid_d = 1'b1;
          state_d       = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // con_busy is deliberately not looked at: the line always completes.
        con_ready            = req_ready[grant_id_q];
        con_char             = req_char[{grant_id_q, 3'b000} +: 8];
        req_next[grant_id_q] = con_next;
        if (req_solved[grant_id_q]) begin
          con_solved_d = 1'b1;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ST_WAIT_ACK;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT_ACK: begin
        // An ack in the limit cycle wins, so it is not flagged as a timeout.
        if (con_ack || (cnt_q == CNT_LAST)) begin
          req_done_d[grant_id_q] = 1'b1;
          rr_ptr_d      = (grant_id_q == ID_LAST) ? {ID_W{1'b0}}
                                                  : grant_id_q + ID_W'(1'b1);
          grant_valid_d = 1'b0;
          err_timeout_d = err_timeout_q | ~con_ack;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= {ID_W{1'b0}};
      grant_id_q    <= {ID_W{1'b0}};
      grant_valid_q <= 1'b0;
      con_solved_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      req_done_q    <= {NUM_REQ{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      con_solved_q  <= con_solved_d;
      err_timeout_q <= err_timeout_d;
      req_done_q    <= req_done_d;
      cnt_q         <= cnt_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign con_solved  = con_solved_q;
  assign req_done    = req_done_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_bash_line_arbiter.sv
// Testbench for bash_line_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// line-level behavioural model.
module tb_bash_line_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ACK_T   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_ready = 4'b0000;
  logic [31:0] req_char = 32'h0;
  logic [3:0]  req_next;
  logic [3:0]  req_solved = 4'b0000;
  logic [3:0]  req_done;
  logic        con_busy = 1'b0;
  logic        con_next = 1'b0;
  logic        con_ready;
  logic [7:0]  con_char;
  logic        con_solved;
  logic        con_ack = 1'b0;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  bash_line_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACK_TIMEOUT(ACK_T)) dut (
    .clk(clk), .rst(rst),
    .req_ready(req_ready), .req_char(req_char), .req_next(req_next),
    .req_solved(req_solved), .req_done(req_done),
    .con_busy(con_busy), .con_next(con_next),
    .con_ready(con_ready), .con_char(con_char), .con_solved(con_solved),
    .con_ack(con_ack),
    .grant_valid(grant_valid), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_line: 0 = channel free, 1 = owner is sending its line,
  //         2 = line handed to display, awaiting acknowledgement.
  int         m_line   = 0;
  int         m_owner  = 0;
  logic [1:0] m_gid    = 2'd0;
  int         m_rr     = 0;
  int         m_wait   = 0;
  logic       m_solved = 1'b0;
  logic [3:0] m_done   = 4'b0000;
  logic       m_err    = 1'b0;

  function automatic int tb_pick(input logic [3:0] ready, input int rr);
    int res;
    res = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (res < 0 && ready[(rr + k) % NUM_REQ]) res = (rr + k) % NUM_REQ;
    end
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_line <= 0; m_owner <= 0; m_gid <= 2'd0; m_rr <= 0; m_wait <= 0;
      m_solved <= 1'b0; m_done <= 4'b0000; m_err <= 1'b0;
    end else begin
      m_solved <= 1'b0;
      m_done   <= 4'b0000;
      if (m_line == 0) begin
        if (!con_busy && tb_pick(req_ready, m_rr) >= 0) begin
          m_owner <= tb_pick(req_ready, m_rr);
          m_gid   <= 2'(tb_pick(req_ready, m_rr));
          m_line  <= 1;
        end
      end else if (m_line == 1) begin
        if (req_solved[m_owner]) begin
          m_solved <= 1'b1;
          m_wait   <= 0;
          m_line   <= 2;
        end
      end else begin
        // this cycle is waiting cycle number m_wait+1
        if (con_ack || (m_wait + 1 >= ACK_T)) begin
          if (!con_ack) m_err <= 1'b1;
          m_done <= 4'b0001 << m_owner;
          m_rr   <= (m_owner + 1) % NUM_REQ;
          m_line <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  // Cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [21:0] exp_v;
    logic [21:0] got_v;
    logic        e_ready;
    logic [7:0]  e_char;
    logic [3:0]  e_next;
    e_ready = 1'b0; e_char = 8'h00; e_next = 4'b0000;
    if (m_line == 1) begin
      e_ready = req_ready[m_owner];
      e_char  = req_char[8*m_owner +: 8];
      e_next  = con_next ? (4'b0001 << m_owner) : 4'b0000;
    end
    exp_v = {(m_line != 0), m_gid, e_ready, e_char, m_solved, e_next, m_done, m_err};
    got_v = {grant_valid, grant_id, con_ready, con_char, con_solved, req_next, req_done, err_timeout};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got=%06h exp=%06h", $time, got_v, exp_v);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_ready = 4'b0000; req_char = 32'h0; req_solved = 4'b0000;
    con_busy = 1'b0; con_next = 1'b0; con_ack = 1'b0;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; clear_inputs();
    tick(); tick(); rst = 1'b0;
  endtask

  logic [1:0] rr_got [5];
  logic [1:0] rr_exp [5];
  logic       prev_gv;
  int         n;
  bit         seen;

  initial begin
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    clear_inputs();
    tick(); tick(); rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_gv", grant_valid, 0); chk("reset_gid", grant_id, 0);
    chk("reset_ready", con_ready, 0); chk("reset_err", err_timeout, 0);

    // Single line "hi" from requester 1
    tick(); req_ready = 4'b0010; req_char[15:8] = 8'h68;
    @(negedge clk); chk("line_pre_gv", grant_valid, 0);
    tick(); con_next = 1'b1;
    @(negedge clk);
    chk("line_gid", grant_id, 1); chk("line_char_h", con_char, 8'h68);
    chk("line_next", req_next, 4'b0010);
    tick(); req_char[15:8] = 8'h69;
    @(negedge clk); chk("line_char_i", con_char, 8'h69);
    tick(); req_char[15:8] = 8'h00; con_next = 1'b0;
    @(negedge clk); chk("line_char_nul", con_char, 8'h00); chk("line_ready", con_ready, 1);
    tick(); req_solved = 4'b0010; req_ready = 4'b0000;
    @(negedge clk); chk("line_solved_early", con_solved, 0);
    tick(); req_solved = 4'b0000;
    @(negedge clk); chk("line_solved", con_solved, 1); chk("line_wait_ready", con_ready, 0);
    tick(); con_ack = 1'b1;
    @(negedge clk); chk("line_solved_once", con_solved, 0);
    tick(); con_ack = 1'b0;
    @(negedge clk); chk("line_done", req_done, 4'b0010); chk("line_gv_off", grant_valid, 0);
    tick();
    @(negedge clk); chk("line_done_once", req_done, 4'b0000);

    // Hold-off while the input line is being read out
    tick(); con_busy = 1'b1; req_ready = 4'b0100; req_char[23:16] = 8'h41;
    repeat (4) begin
      @(negedge clk); chk("holdoff_gv", grant_valid, 0);
      tick();
    end
    con_busy = 1'b0;
    @(negedge clk); chk("holdoff_idle", grant_valid, 0);
    tick();
    @(negedge clk);
    chk("holdoff_gid", grant_id, 2); chk("holdoff_ready", con_ready, 1);
    chk("holdoff_char", con_char, 8'h41);
    tick(); con_busy = 1'b1; con_next = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midline_ready", con_ready, 1); chk("midline_next", req_next, 4'b0100);
      tick();
    end
    req_solved = 4'b0100; req_ready = 4'b0000; con_next = 1'b0;
    tick(); req_solved = 4'b0000; con_ack = 1'b1;
    tick(); con_ack = 1'b0; con_busy = 1'b0;
    @(negedge clk); chk("holdoff_done", req_done, 4'b0100);

    // Round-robin with all requesters continuously ready
    do_reset();
    req_ready = 4'b1111; req_solved = 4'b1111; con_ack = 1'b1;
    prev_gv = 1'b0; n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (grant_valid && !prev_gv) begin
        rr_got[n] = grant_id;
        n++;
      end
      prev_gv = grant_valid;
      tick();
    end
    chk("rr_count", n, 5);
    for (int i = 0; i < 5; i++) chk("rr_seq", rr_got[i], rr_exp[i]);

    // Isolation: requester 3 toggles while requester 0 streams
    do_reset();
    req_ready = 4'b0001; req_char[7:0] = 8'h5a;
    tick(); con_next = 1'b1;
    repeat (6) begin
      tick();
      req_ready[3] = 1'($urandom); req_solved[3] = 1'($urandom); req_char[31:24] = 8'($urandom);
      @(negedge clk);
      chk("iso_gid", grant_id, 0); chk("iso_ready", con_ready, 1);
      chk("iso_next", req_next, 4'b0001); chk("iso_solved", con_solved, 0);
    end

    // Asynchronous reset in the middle of a line
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("arst_out", {grant_valid, grant_id, con_ready, con_char, con_solved, req_next, req_done, err_timeout}, 0);
    req_ready = 4'b1001; req_solved = 4'b0000; con_next = 1'b0;
    tick(); tick(); rst = 1'b0;
    tick();
    @(negedge clk); chk("arst_regrant_gv", grant_valid, 1); chk("arst_regrant_gid", grant_id, 0);

    // Ack timeout
    tick(); req_solved = 4'b0001; req_ready = 4'b0000;
    tick(); req_solved = 4'b0000;
    @(negedge clk); chk("to_solved", con_solved, 1);
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      @(negedge clk);
      n++;
      if (req_done != 4'b0000) begin
        seen = 1'b1;
        chk("to_done", req_done, 4'b0001);
      end
    end
    chk("to_cycles", n, 15); chk("to_err", err_timeout, 1); chk("to_gv", grant_valid, 0);
    repeat (3) tick();
    @(negedge clk); chk("to_err_sticky", err_timeout, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      req_ready  = 4'($urandom_range(0, 15));
      req_char   = $urandom;
      req_solved = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      con_next   = 1'($urandom);
      con_busy   = ($urandom_range(0, 3) == 0);
      con_ack    = ($urandom_range(0, 9) == 0);
    end
    clear_inputs();
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
